// File: rtl/sram_pwr_seq.sv
// sram_pwr_seq: power-state sequencer for a single SRAM bank wrapper.
// Owns the bank power pins and drains in-flight accesses before power-down.
// It gates bus requests so that traffic reaches the bank only in the ON state.
// Handshake: a power command is taken on a clock edge where cmd_valid_i and
// cmd_ready_o are both high. The requester holds cmd_i stable while
// cmd_valid_i is high. cmd_ready_o depends only on the registered state.
module sram_pwr_seq #(
    parameter int AckTimeout = 64,
    parameter int WakeCycles = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_i,
    output logic       cmd_ready_o,
    output logic       cmd_err_o,
    input  logic       mem_req_i,
    output logic       mem_gnt_o,
    output logic       mem_rvalid_o,
    output logic       sram_req_o,
    output logic       sram_pwrgate_no,
    input  logic       sram_pwrgate_ack_ni,
    output logic       sram_set_ret_no,
    output logic [2:0] state_o,
    output logic       timeout_o
);

    localparam int MaxCnt   = (AckTimeout > WakeCycles) ? AckTimeout : WakeCycles;
    localparam int CntWidth = $clog2(MaxCnt + 1);

    localparam logic [CntWidth-1:0] AckLast  = CntWidth'(AckTimeout - 1);
    localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);

    localparam logic [1:0] CmdOn  = 2'b01;
    localparam logic [1:0] CmdOff = 2'b10;
    localparam logic [1:0] CmdRet = 2'b11;

    typedef enum logic [2:0] {
        ST_ON     = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATING = 3'd2,
        ST_OFF    = 3'd3,
        ST_RET    = 3'd4,
        ST_WAKE   = 3'd5,
        ST_SETTLE = 3'd6
    } state_t;

    state_t              state;
    logic [CntWidth-1:0] cnt;
    logic                tgt_ret;
    logic                cmd_fire;

    // Commands are taken only in the three stable states.
    assign cmd_ready_o = (state == ST_ON) || (state == ST_OFF) || (state == ST_RET);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;

    // A power command taking effect this cycle blocks a bus request.
    assign mem_gnt_o  = mem_req_i & (state == ST_ON) & ~(cmd_fire & (cmd_i != CmdOn));
    assign sram_req_o = mem_gnt_o;
    assign state_o    = state;

    // Sequencer FSM with registered power pins, status flags and response valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_ON;
            cnt             <= '0;
            tgt_ret         <= 1'b0;
            sram_pwrgate_no <= 1'b1;
            sram_set_ret_no <= 1'b1;
            mem_rvalid_o    <= 1'b0;
            cmd_err_o       <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            cmd_err_o    <= 1'b0;
            mem_rvalid_o <= mem_gnt_o;
            case (state)
                ST_ON: begin
                    if (cmd_fire && (cmd_i == CmdOff || cmd_i == CmdRet)) begin
                        tgt_ret <= (cmd_i == CmdRet);
                        state   <= ST_DRAIN;
                    end
                end
                // One cycle so the response of the last grant issues.
                ST_DRAIN: begin
                    cnt <= '0;
                    if (tgt_ret) begin
                        sram_set_ret_no <= 1'b0;
                        state           <= ST_RET;
                    end else begin
                        sram_pwrgate_no <= 1'b0;
                        state           <= ST_GATING;
                    end
                end
                ST_GATING: begin
                    if (!sram_pwrgate_ack_ni || cnt == AckLast) begin
                        if (sram_pwrgate_ack_ni) timeout_o <= 1'b1;
                        cnt   <= '0;
                        state <= ST_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cmd_fire && cmd_i == CmdOn) begin
                        sram_pwrgate_no <= 1'b1;
                        cnt             <= '0;
                        state           <= ST_WAKE;
                    end else if (cmd_fire && cmd_i == CmdRet) begin
                        // Retention requires a powered array; reject it from OFF.
                        cmd_err_o <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (sram_pwrgate_ack_ni || cnt == AckLast) begin
                        if (!sram_pwrgate_ack_ni) timeout_o <= 1'b1;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RET: begin
                    if (cmd_fire && cmd_i == CmdOn) begin
                        sram_set_ret_no <= 1'b1;
                        cnt             <= '0;
                        state           <= ST_SETTLE;
                    end else if (cmd_fire && cmd_i == CmdOff) begin
                        sram_set_ret_no <= 1'b1;
                        sram_pwrgate_no <= 1'b0;
                        cnt             <= '0;
                        state           <= ST_GATING;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == WakeLast) begin
                        cnt   <= '0;
                        state <= ST_ON;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_ON;
                end
            endcase
        end
    end

endmodule
